// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the mult/div unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, input busy, hi, lo);
  modport slave  (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. The arithmetic is a
// single-cycle operator on latched operands; the down-counter only sets
// when the result is committed, so the visible latency is fixed per op class.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     a_q, b_q;
  logic [1:0]      op_q;

  logic            div_zero, div_ovf;
  logic [31:0]     dvs;
  logic [63:0]     sprod, uprod;
  logic [31:0]     sq, sr, uq, ur;
  logic [31:0]     res_hi, res_lo;

  assign bus.busy = (state == RUN);

  // Zero divisor and INT_MIN/-1 are patched up below; feed the divider a
  // harmless 1 so the operator never sees those inputs.
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (op_q == 2'd2) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign dvs      = (div_zero || div_ovf) ? 32'd1 : b_q;

  assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign uprod = {32'd0, a_q} * {32'd0, b_q};
  assign sq    = $signed(a_q) / $signed(dvs);
  assign sr    = $signed(a_q) % $signed(dvs);
  assign uq    = a_q / dvs;
  assign ur    = a_q % dvs;

  // Select the result to commit for the latched operation.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'd0: {res_hi, res_lo} = sprod;
      2'd1: {res_hi, res_lo} = uprod;
      2'd2: begin
        if (div_zero)     begin res_hi = a_q;   res_lo = 32'hFFFF_FFFF; end
        else if (div_ovf) begin res_hi = '0;    res_lo = 32'h8000_0000; end
        else              begin res_hi = sr;    res_lo = sq;            end
      end
      default: begin
        if (div_zero) begin res_hi = a_q; res_lo = 32'hFFFF_FFFF; end
        else          begin res_hi = ur;  res_lo = uq;            end
      end
    endcase
  end

  // Issue/count/commit FSM; HI/LO writes happen only here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_q   <= bus.A;
              b_q   <= bus.B;
              op_q  <= bus.op[1:0];
              cnt   <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state <= RUN;
            end
            3'd4:    bus.hi <= bus.A;
            3'd5:    bus.lo <= bus.A;
            default: ;
          endcase
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            bus.hi <= res_hi;
            bus.lo <= res_lo;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic corners, input
// isolation during RUN, idle MTHI/MTLO and reset abort.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Present one issue for exactly one rising edge; returns at the
  // falling edge right after it (first busy cycle for mult/div ops).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd6;
  endtask

  // Count sampled busy cycles, bounded so a stuck busy cannot hang.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.op = 3'd6; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int cyc;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", bus.lo); end
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL multu_busy_cycles got=%0d exp=5", cyc); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
  endtask

  task automatic test_div;
    int cyc;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
    issue(3'd3, 32'd7, 32'd2);
    wait_done(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++; if (bus.lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got=%h exp=3", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got=%h exp=1", bus.hi); end
  endtask

  task automatic test_div_corner;
    int cyc;
    issue(3'd3, 32'd5, 32'd0);
    wait_done(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divzero_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divzero_lo got=%h exp=ffffffff", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd5) begin n_bad++; $display("FAIL divzero_hi got=%h exp=5", bus.hi); end
    issue(3'd2, 32'hFFFF_FFF3, 32'd0);
    wait_done(cyc);
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sdivzero_lo got=%h exp=ffffffff", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFF3) begin n_bad++; $display("FAIL sdivzero_hi got=%h exp=fffffff3", bus.hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_cmp++; if (bus.lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo got=%h exp=80000000", bus.lo); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi got=%h exp=0", bus.hi); end
  endtask

  task automatic test_isolation;
    int cyc;
    issue(3'd1, 32'd3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL iso_busy k=%0d got=%b exp=1", k, bus.busy); end
      n_cmp++; if (bus.lo !== 32'h8000_0000) begin n_bad++; $display("FAIL iso_lo_hold k=%0d got=%h exp=80000000", k, bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL iso_hi_hold k=%0d got=%h exp=0", k, bus.hi); end
      bus.A = 32'h100 + k; bus.B = ~k;
      if (k == 1) begin bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hDEAD; end
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd6;
    end
    wait_done(cyc);
    n_cmp++; if (bus.lo !== 32'd12) begin n_bad++; $display("FAIL iso_lo got=%h exp=c", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL iso_hi got=%h exp=0", bus.hi); end
    issue(3'd5, 32'h1234, 32'd0);
    n_cmp++; if (bus.lo !== 32'h1234) begin n_bad++; $display("FAIL mtlo_lo got=%h exp=1234", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL mtlo_hi got=%h exp=0", bus.hi); end
    issue(3'd4, 32'h55, 32'd0);
    n_cmp++; if (bus.hi !== 32'h55) begin n_bad++; $display("FAIL mthi_hi got=%h exp=55", bus.hi); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    issue(3'd7, 32'h77, 32'd0);
    n_cmp++; if (bus.busy !== 1'b0 || bus.hi !== 32'h55 || bus.lo !== 32'h1234)
      begin n_bad++; $display("FAIL nop_effect busy=%b hi=%h lo=%h exp busy=0 hi=55 lo=1234", bus.busy, bus.hi, bus.lo); end
  endtask

  task automatic test_abort;
    issue(3'd2, 32'd100, 32'd7);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_start got=%b exp=1", bus.busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL abort_hi got=%h exp=0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo got=%h exp=0", bus.lo); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0)
        begin n_bad++; $display("FAIL abort_quiet k=%0d busy=%b hi=%h lo=%h exp all 0", k, bus.busy, bus.hi, bus.lo); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(3'd0, 32'd6, 32'hFFFF_FFFE);
    wait_done(cyc);
    issue(3'd3, 32'd100, 32'd7);
    wait_done(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL b2b_busy_cycles got=%0d exp=10", cyc); end
    n_cmp++; if (bus.lo !== 32'd14) begin n_bad++; $display("FAIL b2b_lo got=%h exp=e", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd2) begin n_bad++; $display("FAIL b2b_hi got=%h exp=2", bus.hi); end
    issue(3'd0, 32'd6, 32'hFFFF_FFFE);
    wait_done(cyc);
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_mult_hi got=%h exp=ffffffff", bus.hi); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFF4) begin n_bad++; $display("FAIL b2b_mult_lo got=%h exp=fffffff4", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_isolation();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the two source operands read from the register file (rs/rt, already forwarded) and owns the architectural HI/LO registers.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with multi-cycle latency and a busy flag.
- The hazard unit uses the busy flag to stall MFHI/MFLO and further mult/div instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe, sampled on the rising edge.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  high while a multiply/divide is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset:
  - One clocked cycle with reset=1 forces hi=0, lo=0 and busy=0.
  - It clears the cycle counter and discards any in-flight operation.
  - No result from that operation is ever committed.
  - Reset overrides start in the same cycle.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - A down-counter holds the remaining cycles.
- IDLE, start=1, op∈{0..3}:
  - Latch A, B and op into internal registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4: hi<=A at this edge. op=5: lo<=A at this edge. busy stays 0.
- IDLE, start=1, op=6/7: no effect.
- RUN:
  - Decrement the counter each edge.
  - On the edge where the counter goes 1→0, write the result to hi/lo and return to IDLE.
  - busy=0 in the same cycle the new hi/lo become visible.
- Latency: with start sampled at edge T, busy=1 during cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES). New hi/lo and busy=0 appear after edge T+N.
- Ignored inputs during RUN:
  - start is ignored for every op, including MTHI/MTLO; the hazard unit must not issue them.
  - Changes to A/B are ignored; the latched operands are used.
- hi/lo hold their previous values during RUN. They change only at completion, at MTHI/MTLO, or at reset.
- MULT: the 64-bit signed product of the latched operands; hi = [63:32], lo = [31:0].
- MULTU: the same, with an unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: lo and hi are the unsigned quotient and remainder.
- Division by zero (DIV and DIVU): lo = 32'hFFFFFFFF, hi = dividend A. busy timing is unchanged.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): lo = 32'h80000000, hi = 0.
- The arithmetic method (iterative or single-cycle operator followed by a delay) is free, provided the cycle timing above holds exactly.
- busy is a register output; hi and lo are register outputs.
- No combinational path from any input to any output.

Test Plan:
- Reset then MULT A=32'hFFFFFFFD (-3), B=7 → busy=1 for exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU A=B=32'hFFFFFFFF → after 5 cycles hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV A=-7 (32'hFFFFFFF9), B=2 → busy 10 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU A=7, B=2 → lo=3, hi=1.
- DIVU A=5, B=0 → lo=32'hFFFFFFFF, hi=5. DIV A=32'h80000000, B=32'hFFFFFFFF → lo=32'h80000000, hi=0.
- Operand/issue isolation, starting from MULTU A=3, B=4:
  - Change A/B every cycle during busy, and pulse start with MTHI A=32'hDEAD.
  - Result must be lo=12, hi=0, with no hi write from the MTHI.
  - A later idle MTLO A=32'h1234 sets lo=32'h1234 one edge after start, with busy staying 0.
- Abort mid-operation: DIV 100/7 with reset asserted on the 3rd busy cycle → next cycle busy=0, hi=lo=0. Both stay 0 for 15 more cycles.
